alu_exec_unit: RTL and testbench

- Execution stage directly downstream of the ALU reservation station.
- Consumes the one-cycle issue packet ALU_valid/op/reg1/reg2/imm/pc/reg_des_rob and produces the ALU CDB broadcast (ALU_cdb_valid/tag/data) that every RS, the LSB and the ROB snoop.
- RV32I integer ops finish in one cycle. RV32M multiply (and divide, optionally) run in an iterative FSM. ALU_busy throttles the RS while the FSM is occupied.

---
 rtl/alu_exec_unit.sv | 278 +++++++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// ALU execution stage: single-cycle RV32I ops plus an iterative RV32M multiplier feeding the ALU CDB.
// Define ALU_DIV_EN to build the iterative divider for DIV/DIVU/REM/REMU; otherwise those ops return 0.
module alu_exec_unit #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 6,
  parameter int ITER   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              ALU_valid,
  input  logic [OP_W-1:0]   ALU_op,
  input  logic [DATA_W-1:0] ALU_reg1,
  input  logic [DATA_W-1:0] ALU_reg2,
  input  logic [DATA_W-1:0] ALU_imm,
  input  logic [DATA_W-1:0] ALU_pc,
  input  logic [TAG_W-1:0]  ALU_reg_des_rob,
  output logic              ALU_busy,
  output logic              ALU_cdb_valid,
  output logic [TAG_W-1:0]  ALU_cdb_tag,
  output logic [DATA_W-1:0] ALU_cdb_data
);

  // Op encodings mirror the OP_* values of cpu_define.v.
  localparam logic [OP_W-1:0] OP_ADD    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB    = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SLL    = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SLT    = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SLTU   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_XOR    = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL    = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRA    = OP_W'(7);
  localparam logic [OP_W-1:0] OP_OR     = OP_W'(8);
  localparam logic [OP_W-1:0] OP_AND    = OP_W'(9);
  localparam logic [OP_W-1:0] OP_ADDI   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_SLLI   = OP_W'(11);
  localparam logic [OP_W-1:0] OP_SLTI   = OP_W'(12);
  localparam logic [OP_W-1:0] OP_SLTIU  = OP_W'(13);
  localparam logic [OP_W-1:0] OP_XORI   = OP_W'(14);
  localparam logic [OP_W-1:0] OP_SRLI   = OP_W'(15);
  localparam logic [OP_W-1:0] OP_SRAI   = OP_W'(16);
  localparam logic [OP_W-1:0] OP_ORI    = OP_W'(17);
  localparam logic [OP_W-1:0] OP_ANDI   = OP_W'(18);
  localparam logic [OP_W-1:0] OP_LUI    = OP_W'(19);
  localparam logic [OP_W-1:0] OP_AUIPC  = OP_W'(20);
  localparam logic [OP_W-1:0] OP_MUL    = OP_W'(21);
  localparam logic [OP_W-1:0] OP_MULH   = OP_W'(22);
  localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(23);
  localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(24);
  localparam logic [OP_W-1:0] OP_DIV    = OP_W'(25);
  localparam logic [OP_W-1:0] OP_DIVU   = OP_W'(26);
  localparam logic [OP_W-1:0] OP_REM    = OP_W'(27);
  localparam logic [OP_W-1:0] OP_REMU   = OP_W'(28);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
`ifdef ALU_DIV_EN
    S_DIV,
`endif
    S_DONE
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] hi_q, lo_q, b_q;
  logic [OP_W-1:0]   op_q;
  logic [TAG_W-1:0]  tag_q;
  logic              qneg_q;
`ifdef ALU_DIV_EN
  logic              rneg_q, dz_q;
`endif
  logic              cdb_valid_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [DATA_W-1:0] cdb_data_q;

  logic              is_multi, is_div, sa, sb;
  logic [DATA_W-1:0] mag_a, mag_b, op2, alu_res, final_res;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W-1:0] mul_hi_d, mul_lo_d;
  logic [2*DATA_W-1:0] prod_s;
`ifdef ALU_DIV_EN
  logic [DATA_W:0]   div_sh, div_diff;
  logic [DATA_W-1:0] div_hi_d, div_lo_d;
`endif

  always_comb begin
    is_multi = 1'b0;
    is_div   = 1'b0;
    sa       = 1'b0;
    sb       = 1'b0;
    case (ALU_op)
      OP_MUL, OP_MULHU: is_multi = 1'b1;
      OP_MULH: begin
        is_multi = 1'b1;
        sa       = ALU_reg1[DATA_W-1];
        sb       = ALU_reg2[DATA_W-1];
      end
      OP_MULHSU: begin
        is_multi = 1'b1;
        sa       = ALU_reg1[DATA_W-1];
      end
`ifdef ALU_DIV_EN
      OP_DIVU, OP_REMU: begin
        is_multi = 1'b1;
        is_div   = 1'b1;
      end
      OP_DIV, OP_REM: begin
        is_multi = 1'b1;
        is_div   = 1'b1;
        sa       = ALU_reg1[DATA_W-1];
        sb       = ALU_reg2[DATA_W-1];
      end
`endif
      default: ;
    endcase
    mag_a = sa ? (~ALU_reg1 + 1'b1) : ALU_reg1;
    mag_b = sb ? (~ALU_reg2 + 1'b1) : ALU_reg2;
  end

  assign ALU_busy = (state_q != S_IDLE) | (ALU_valid & is_multi);

  always_comb begin
    op2 = ALU_reg2;
    case (ALU_op)
      OP_ADDI, OP_SLLI, OP_SLTI, OP_SLTIU, OP_XORI,
      OP_SRLI, OP_SRAI, OP_ORI, OP_ANDI, OP_LUI, OP_AUIPC: op2 = ALU_imm;
      default: ;
    endcase
    alu_res = '0;
    case (ALU_op)
      OP_ADD, OP_ADDI:   alu_res = ALU_reg1 + op2;
      OP_SUB:            alu_res = ALU_reg1 - op2;
      OP_SLL, OP_SLLI:   alu_res = ALU_reg1 << op2[4:0];
      OP_SLT, OP_SLTI:   alu_res = {{(DATA_W-1){1'b0}}, $signed(ALU_reg1) < $signed(op2)};
      OP_SLTU, OP_SLTIU: alu_res = {{(DATA_W-1){1'b0}}, ALU_reg1 < op2};
      OP_XOR, OP_XORI:   alu_res = ALU_reg1 ^ op2;
      OP_SRL, OP_SRLI:   alu_res = ALU_reg1 >> op2[4:0];
      OP_SRA, OP_SRAI:   alu_res = $unsigned($signed(ALU_reg1) >>> op2[4:0]);
      OP_OR, OP_ORI:     alu_res = ALU_reg1 | op2;
      OP_AND, OP_ANDI:   alu_res = ALU_reg1 & op2;
      OP_LUI:            alu_res = op2;
      OP_AUIPC:          alu_res = ALU_pc + op2;
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: alu_res = '0;
      default:           alu_res = '0;
    endcase
  end

  // Shift-add step on {hi,lo}: multiplier consumed from lo[0], product bits shift in from the top.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    mul_hi_d = mul_sum[DATA_W:1];
    mul_lo_d = {mul_sum[0], lo_q[DATA_W-1:1]};
  end

`ifdef ALU_DIV_EN
  // Restoring step: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
  always_comb begin
    div_sh   = {hi_q, lo_q[DATA_W-1]};
    div_diff = div_sh - {1'b0, b_q};
    if (!div_diff[DATA_W]) begin
      div_hi_d = div_diff[DATA_W-1:0];
      div_lo_d = {lo_q[DATA_W-2:0], 1'b1};
    end else begin
      div_hi_d = div_sh[DATA_W-1:0];
      div_lo_d = {lo_q[DATA_W-2:0], 1'b0};
    end
  end
`endif

  always_comb begin
    prod_s    = qneg_q ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
    final_res = prod_s[DATA_W-1:0];
    case (op_q)
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_s[2*DATA_W-1:DATA_W];
`ifdef ALU_DIV_EN
      OP_DIV, OP_DIVU: final_res = dz_q ? '1 : (qneg_q ? (~lo_q + 1'b1) : lo_q);
      OP_REM, OP_REMU: final_res = rneg_q ? (~hi_q + 1'b1) : hi_q;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      b_q         <= '0;
      op_q        <= '0;
      tag_q       <= '0;
      qneg_q      <= 1'b0;
`ifdef ALU_DIV_EN
      rneg_q      <= 1'b0;
      dz_q        <= 1'b0;
`endif
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
    end else if (rdy) begin
      if (clear) begin
        state_q     <= S_IDLE;
        cnt_q       <= '0;
        cdb_valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            cdb_valid_q <= 1'b0;
            if (ALU_valid) begin
              if (is_multi) begin
                hi_q   <= '0;
                op_q   <= ALU_op;
                tag_q  <= ALU_reg_des_rob;
                qneg_q <= sa ^ sb;
                cnt_q  <= '0;
`ifdef ALU_DIV_EN
                rneg_q <= sa;
                dz_q   <= (ALU_reg2 == '0);
                if (is_div) begin
                  lo_q    <= mag_a;
                  b_q     <= mag_b;
                  state_q <= S_DIV;
                end else
`endif
                begin
                  lo_q    <= mag_b;
                  b_q     <= mag_a;
                  state_q <= is_div ? S_DONE : S_MUL;
                end
              end else begin
                cdb_valid_q <= 1'b1;
                cdb_tag_q   <= ALU_reg_des_rob;
                cdb_data_q  <= alu_res;
              end
            end
          end
          S_MUL: begin
            hi_q  <= mul_hi_d;
            lo_q  <= mul_lo_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(ITER - 1)) begin
              cnt_q   <= '0;
              state_q <= S_DONE;
            end
          end
`ifdef ALU_DIV_EN
          S_DIV: begin
            hi_q  <= div_hi_d;
            lo_q  <= div_lo_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(ITER - 1)) begin
              cnt_q   <= '0;
              state_q <= S_DONE;
            end
          end
`endif
          S_DONE: begin
            cdb_valid_q <= 1'b1;
            cdb_tag_q   <= tag_q;
            cdb_data_q  <= final_res;
            state_q     <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign ALU_cdb_valid = cdb_valid_q;
  assign ALU_cdb_tag   = cdb_tag_q;
  assign ALU_cdb_data  = cdb_data_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: single-cycle vector table plus multi-cycle, clear, stall and reset sequences.
module tb_alu_exec_unit;

  localparam logic [5:0] OP_ADD = 6'd0,  OP_SUB = 6'd1,  OP_SLL = 6'd2,  OP_SLT = 6'd3;
  localparam logic [5:0] OP_SLTU = 6'd4, OP_XOR = 6'd5,  OP_SRL = 6'd6,  OP_SRA = 6'd7;
  localparam logic [5:0] OP_OR = 6'd8,   OP_AND = 6'd9,  OP_ADDI = 6'd10, OP_SLTI = 6'd12;
  localparam logic [5:0] OP_SLTIU = 6'd13, OP_SRAI = 6'd16, OP_ANDI = 6'd18;
  localparam logic [5:0] OP_LUI = 6'd19, OP_AUIPC = 6'd20, OP_MUL = 6'd21, OP_MULH = 6'd22;
  localparam logic [5:0] OP_MULHSU = 6'd23, OP_MULHU = 6'd24, OP_DIV = 6'd25, OP_DIVU = 6'd26;
  localparam logic [5:0] OP_REM = 6'd27, OP_REMU = 6'd28;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, valid;
  logic [5:0]  op;
  logic [31:0] reg1, reg2, imm, pc;
  logic [3:0]  tag;
  logic        busy, cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.DATA_W(32), .TAG_W(4), .OP_W(6), .ITER(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .ALU_valid(valid), .ALU_op(op), .ALU_reg1(reg1), .ALU_reg2(reg2),
    .ALU_imm(imm), .ALU_pc(pc), .ALU_reg_des_rob(tag),
    .ALU_busy(busy), .ALU_cdb_valid(cdb_valid), .ALU_cdb_tag(cdb_tag), .ALU_cdb_data(cdb_data)
  );

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] r1, r2, imm, pc;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string n, input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] i, input logic [31:0] p, input logic [3:0] t, input logic [31:0] e);
    vec_t v;
    v.name = n; v.op = o; v.r1 = a; v.r2 = b; v.imm = i; v.pc = p; v.tag = t; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    valid = 1'b1; op = o; reg1 = a; reg2 = b; imm = 32'h0; pc = 32'h0; tag = t;
  endtask

  // Issue at the current negedge, expect the result ITER+2 cycles later with busy held meanwhile.
  task automatic run_multi(input string n, input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] t, input logic [31:0] e, input bit stray);
    issue(o, a, b, t);
    #1 chk({n, " busy@issue"}, {31'b0, busy}, 32'd1);
    for (int j = 1; j <= 33; j++) begin
      @(negedge clk);
      valid = stray && (j == 5);
      op    = (stray && j == 5) ? OP_ADD : o;
      chk({n, " busy"}, {31'b0, busy}, 32'd1);
      chk({n, " no early cdb"}, {31'b0, cdb_valid}, 32'd0);
    end
    @(negedge clk);
    valid = 1'b0;
    chk({n, " cdb_valid"}, {31'b0, cdb_valid}, 32'd1);
    chk({n, " cdb_tag"}, {28'b0, cdb_tag}, {28'b0, t});
    chk({n, " cdb_data"}, cdb_data, e);
    chk({n, " busy@done"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; valid = 1'b0;
    op = '0; reg1 = '0; reg2 = '0; imm = '0; pc = '0; tag = '0;

    add_vec("ADD wrap", OP_ADD,   32'h7FFFFFFF, 32'h1,        32'h0,        32'h0,    4'd3, 32'h80000000);
    add_vec("SUB",      OP_SUB,   32'h5,        32'h7,        32'h0,        32'h0,    4'd1, 32'hFFFFFFFE);
    add_vec("SLL",      OP_SLL,   32'h1,        32'h21,       32'h0,        32'h0,    4'd2, 32'h2);
    add_vec("SLT",      OP_SLT,   32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,    4'd4, 32'h1);
    add_vec("SLTU",     OP_SLTU,  32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,    4'd5, 32'h0);
    add_vec("XOR",      OP_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'h0,    4'd6, 32'h0FF00FF0);
    add_vec("SRL",      OP_SRL,   32'h80000000, 32'h1F,       32'h0,        32'h0,    4'd7, 32'h1);
    add_vec("SRA",      OP_SRA,   32'h80000000, 32'h1F,       32'h0,        32'h0,    4'd8, 32'hFFFFFFFF);
    add_vec("OR",       OP_OR,    32'h00000F00, 32'h000000F0, 32'h0,        32'h0,    4'd9, 32'h00000FF0);
    add_vec("AND",      OP_AND,   32'hFF00FF00, 32'h0FF00FF0, 32'h0,        32'h0,    4'd10, 32'h0F000F00);
    add_vec("ADDI",     OP_ADDI,  32'h10,       32'h1234,     32'hFFFFFFFF, 32'h0,    4'd11, 32'hF);
    add_vec("SLTI",     OP_SLTI,  32'hFFFFFFFB, 32'h0,        32'hFFFFFFFC, 32'h0,    4'd12, 32'h1);
    add_vec("SLTIU",    OP_SLTIU, 32'h5,        32'h0,        32'h6,        32'h0,    4'd13, 32'h1);
    add_vec("SRAI",     OP_SRAI,  32'h80000010, 32'h0,        32'h24,       32'h0,    4'd14, 32'hF8000001);
    add_vec("ANDI",     OP_ANDI,  32'h0000FFFF, 32'hFFFFFFFF, 32'h00000F0F, 32'h0,    4'd15, 32'h00000F0F);
    add_vec("LUI",      OP_LUI,   32'hDEADBEEF, 32'h0,        32'h12345000, 32'h0,    4'd0, 32'h12345000);
    add_vec("AUIPC",    OP_AUIPC, 32'h0,        32'h0,        32'h2000,     32'h1000, 4'd3, 32'h3000);
`ifndef ALU_DIV_EN
    add_vec("DIV off",  OP_DIV,   32'h5,        32'h0,        32'h0,        32'h0,    4'd6, 32'h0);
    add_vec("REMU off", OP_REMU,  32'h64,       32'h7,        32'h0,        32'h0,    4'd7, 32'h0);
`endif

    @(negedge clk);
    chk("reset cdb_valid", {31'b0, cdb_valid}, 32'd0);
    chk("reset cdb_tag", {28'b0, cdb_tag}, 32'd0);
    chk("reset cdb_data", cdb_data, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;

    // Back-to-back single-cycle issues
    foreach (vecs[i]) begin
      valid = 1'b1; op = vecs[i].op; reg1 = vecs[i].r1; reg2 = vecs[i].r2;
      imm = vecs[i].imm; pc = vecs[i].pc; tag = vecs[i].tag;
      #1 chk({vecs[i].name, " busy"}, {31'b0, busy}, 32'd0);
      @(negedge clk);
      chk({vecs[i].name, " valid"}, {31'b0, cdb_valid}, 32'd1);
      chk({vecs[i].name, " tag"}, {28'b0, cdb_tag}, {28'b0, vecs[i].tag});
      chk({vecs[i].name, " data"}, cdb_data, vecs[i].exp);
    end
    valid = 1'b0;
    @(negedge clk);
    chk("single pulse", {31'b0, cdb_valid}, 32'd0);

    // Multiply, first one with a stray issue while busy that must be dropped
    run_multi("MUL", OP_MUL, 32'd7, 32'hFFFFFFFD, 4'd9, 32'hFFFFFFEB, 1'b1);
    run_multi("MULH min", OP_MULH, 32'h80000000, 32'h80000000, 4'd2, 32'h40000000, 1'b0);
    run_multi("MULH -1", OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd3, 32'h0, 1'b0);
    run_multi("MULHU", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd4, 32'hFFFFFFFE, 1'b0);
    run_multi("MULHSU", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd5, 32'hFFFFFFFF, 1'b0);
`ifdef ALU_DIV_EN
    run_multi("DIV by0", OP_DIV, 32'd5, 32'h0, 4'd6, 32'hFFFFFFFF, 1'b0);
    run_multi("REM by0", OP_REM, 32'd5, 32'h0, 4'd7, 32'd5, 1'b0);
    run_multi("REM neg", OP_REM, 32'hFFFFFFF9, 32'd2, 4'd8, 32'hFFFFFFFF, 1'b0);
    run_multi("DIV neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 4'd9, 32'hFFFFFFFD, 1'b0);
    run_multi("DIV ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 4'd10, 32'h80000000, 1'b0);
    run_multi("REM ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 4'd11, 32'h0, 1'b0);
    run_multi("DIVU", OP_DIVU, 32'd100, 32'd7, 4'd12, 32'd14, 1'b0);
    run_multi("REMU", OP_REMU, 32'd100, 32'd7, 4'd13, 32'd2, 1'b0);
`endif
    @(negedge clk);
    chk("post multi idle", {31'b0, cdb_valid}, 32'd0);

    // Clear mid-multiply, then an immediate single-cycle issue
    issue(OP_MUL, 32'd3, 32'd3, 4'd1);
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      valid = 1'b0;
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear busy", {31'b0, busy}, 32'd0);
    chk("clear cdb", {31'b0, cdb_valid}, 32'd0);
    issue(OP_ADD, 32'd20, 32'd22, 4'd7);
    @(negedge clk);
    valid = 1'b0;
    chk("after clear valid", {31'b0, cdb_valid}, 32'd1);
    chk("after clear tag", {28'b0, cdb_tag}, 32'd7);
    chk("after clear data", cdb_data, 32'd42);
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      chk("no stale after clear", {31'b0, cdb_valid}, 32'd0);
    end

    // Clear in the DONE cycle wins over the CDB write
    issue(OP_MUL, 32'd3, 32'd3, 4'd2);
    for (int j = 1; j <= 33; j++) begin
      @(negedge clk);
      valid = 1'b0;
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear at done", {31'b0, cdb_valid}, 32'd0);

    // Clear with a same-cycle single-cycle issue discards it
    issue(OP_ADD, 32'd1, 32'd1, 4'd3);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; valid = 1'b0;
    chk("clear same-cycle issue", {31'b0, cdb_valid}, 32'd0);

    // rdy low: no acceptance, and outputs hold
    issue(OP_ADD, 32'd1, 32'd1, 4'd4);
    rdy = 1'b0;
    @(negedge clk);
    chk("rdy0 no accept", {31'b0, cdb_valid}, 32'd0);
    rdy = 1'b1;
    issue(OP_ADD, 32'd2, 32'd3, 4'd5);
    @(negedge clk);
    valid = 1'b0; rdy = 1'b0;
    chk("pre-stall valid", {31'b0, cdb_valid}, 32'd1);
    @(negedge clk);
    chk("stall hold valid", {31'b0, cdb_valid}, 32'd1);
    chk("stall hold data", cdb_data, 32'd5);
    rdy = 1'b1;
    @(negedge clk);
    chk("stall release", {31'b0, cdb_valid}, 32'd0);

    // rdy low for three cycles mid-multiply stretches latency by three
    issue(OP_MUL, 32'd6, 32'd7, 4'd6);
    for (int j = 1; j <= 37; j++) begin
      @(negedge clk);
      valid = 1'b0;
      if (j < 37) chk("stalled mul wait", {31'b0, cdb_valid}, 32'd0);
      else begin
        chk("stalled mul valid", {31'b0, cdb_valid}, 32'd1);
        chk("stalled mul data", cdb_data, 32'd42);
      end
      rdy = !(j >= 3 && j <= 5);
    end
    rdy = 1'b1;

    // Asynchronous reset mid-multiply
    issue(OP_MUL, 32'd9, 32'd9, 4'd8);
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      valid = 1'b0;
    end
    #2 rst = 1'b1;
    #1 chk("async rst cdb_valid", {31'b0, cdb_valid}, 32'd0);
    chk("async rst busy", {31'b0, busy}, 32'd0);
    chk("async rst data", cdb_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      chk("no stale after rst", {31'b0, cdb_valid}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
